seq_multiplier_taint_signed: RTL and testbench
==============================================

Name: seq_multiplier_taint_signed

Overview:
Next-generation constant-time shift-add sequential multiplier with bitwise taint (information-flow) tracking. It supports a run-time signed/unsigned mode and a start/busy/done handshake. Every data and control input has a `_t` shadow, and every output carries a taint shadow computed by the fixed rules below. It slots into the taint-tracking multiplier hierarchy as a single self-contained block with control and datapath merged.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64; product is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start, start_t  input  1  request to begin a multiply, and its taint.
- signed_mode, signed_mode_t  input  1  1 = two's-complement operands, 0 = unsigned; taint.
- multiplier, multiplier_t  input  WIDTH  operand A and its per-bit taint.
- multiplicand, multiplicand_t  input  WIDTH  operand B and its per-bit taint.
- busy, busy_t  output  1  operation in progress; taint.
- product, product_t  output  2*WIDTH  result and its per-bit taint.
- product_done, product_done_t  output  1  result valid; taint.

Behaviour:
- Reset (rst high at a clock edge) takes priority over everything and can occur mid-operation:
  - the FSM goes to IDLE;
  - busy, product, product_done and all `_t` outputs and internal shadows become 0;
  - any in-flight operation is discarded.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: on start=1, latch both operands, signed_mode and all of their taints; go to LOAD. busy=0.
  - LOAD (1 cycle):
    - clear the 2*WIDTH+1 running sum and its shadow;
    - load the multiplicand register: sign-extended to 2*WIDTH+1 if signed_mode, else zero-extended; the taint shadow is extended the same way, with sign bits copying multiplicand_t[WIDTH-1];
    - counter=0; go to RUN. busy=1.
  - RUN (exactly WIDTH cycles, i = counter):
    - If mr[i]=1: the addend is md<<i, except at i=WIDTH-1 in signed mode, where the addend is negated (subtract). Otherwise the addend is 0.
    - The sum is written every cycle regardless of mr[i]. Timing must not depend on data.
    - After i=WIDTH-1, go to DONE. busy=1.
  - DONE:
    - product = running sum [2*WIDTH-1:0];
    - product_done=1 and product_done_t = start_t latched at accept;
    - busy=0.
    - Outputs hold until the next start is accepted. start=1 in DONE is accepted exactly as in IDLE (same cycle), product_done drops, and LOAD follows.
- start while busy (LOAD/RUN) is ignored; it causes no state or taint change.
- Latency: start accepted at edge N → product_done=1 visible after edge N+WIDTH+2. The cycle count is identical for all operand values and both modes.
- Taint rules, applied each RUN cycle:
  - Control taint: ct = mr_t[i] | (signed_mode_t & (i==WIDTH-1)).
  - Addend taint:
    - if ct: all bits at positions ≥ i;
    - else if mr[i]: md_t<<i;
    - else: 0.
    - A negated addend's taint is its taint with all bits above its lowest tainted bit also set.
  - Sum taint: let k = lowest set bit of (rs_t | add_t). New rs_t sets bits k..2*WIDTH, and keeps the old rs_t bits below k. If there is no set bit, rs_t stays 0.
  - product_t = rs_t[2*WIDTH-1:0] at DONE.
  - busy_t = start_t latched.
  - signed_mode_t additionally taints product bit 2*WIDTH-1 and above the lowest tainted bit of the sign-extension region.
- Arithmetic: the running sum is 2*WIDTH+1 bits, and only the low 2*WIDTH bits are the result.
  - Unsigned result = A*B exact.
  - Signed result = two's-complement A*B exact, including −2^(WIDTH-1) × −2^(WIDTH-1).
- Untainted inputs (all `_t`=0) must yield all `_t` outputs 0.

Test Plan:
- WIDTH=8, unsigned, A=0xFF, B=0xFF, no taint → product=0xFE01, product_done after 10 cycles, product_t=0, product_done_t=0.
- WIDTH=8, signed, A=0x80, B=0x80 → product=0x4000; A=0xFF (−1), B=0x03 → product=0xFFFD; both in identical cycle count.
- WIDTH=8, unsigned, A=0x01, B=0x01, multiplicand_t=0x01 → product=0x0001, product_t=0xFFFF (taint smears from bit 0).
- WIDTH=8, A=0x00 with multiplier_t=0x10, B=0x05 untainted → product=0x0000, product_t=0xFFF0.
- Reset asserted in RUN at counter=3 → next cycle busy=0, product=0, all taints 0. start=1 while busy → ignored, latency unchanged. start in DONE → product_done falls next cycle.
- Random WIDTH=16 and WIDTH=32 regression, both modes, zero taint → product matches the reference model; every `_t`=0; latency constant at WIDTH+2.

Source files
------------

// File: rtl/seq_multiplier_taint_signed.sv
// Constant-time shift-add multiplier (signed/unsigned) with bitwise taint tracking.
// Each RUN cycle always writes the running sum, so latency never depends on data.
module seq_multiplier_taint_signed #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               start_t,
  input  logic               signed_mode,
  input  logic               signed_mode_t,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplier_t,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplicand_t,
  output logic               busy,
  output logic               busy_t,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_t,
  output logic               product_done,
  output logic               product_done_t
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SW    = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  mr_q, mr_d, mr_t_q, mr_t_d;
  logic [WIDTH-1:0]  mc_q, mc_d, mc_t_q, mc_t_d;
  logic              sm_q, sm_d, sm_t_q, sm_t_d;
  logic              st_t_q, st_t_d;
  logic [SW-1:0]     md_q, md_d, md_t_q, md_t_d;
  logic [SW-1:0]     rs_q, rs_d, rs_t_q, rs_t_d;
  logic              busy_q, busy_d;
  logic [PW-1:0]     product_q, product_d, product_t_q, product_t_d;
  logic              done_q, done_d, done_t_q, done_t_d;

  // Run-step datapath signals
  logic [WIDTH-1:0]  mr_sh_c, mr_t_sh_c;
  logic              mr_bit_c, mr_t_bit_c, last_c, neg_c, ct_c;
  logic [SW-1:0]     addend_c, sum_c, add_t_c, step_t_c;
  logic              accept_c;

  // Sets every bit from the lowest set bit of x upward (x | -x)
  function automatic logic [SW-1:0] smear_up(input logic [SW-1:0] x);
    return x | (~x + SW'(1));
  endfunction

  // One shift-add iteration and its taint propagation
  always_comb begin
    mr_sh_c    = mr_q >> cnt_q;
    mr_t_sh_c  = mr_t_q >> cnt_q;
    mr_bit_c   = mr_sh_c[0];
    mr_t_bit_c = mr_t_sh_c[0];
    last_c     = (cnt_q == CNT_W'(WIDTH - 1));
    neg_c      = sm_q & last_c & mr_bit_c;
    addend_c   = mr_bit_c ? (md_q << cnt_q) : '0;
    sum_c      = neg_c ? (rs_q - addend_c) : (rs_q + addend_c);
    ct_c       = mr_t_bit_c | (sm_t_q & last_c);
    if (ct_c) begin
      add_t_c = {SW{1'b1}} << cnt_q;
    end else if (mr_bit_c) begin
      add_t_c = md_t_q << cnt_q;
    end else begin
      add_t_c = '0;
    end
    if (neg_c) begin
      add_t_c = smear_up(add_t_c);
    end
    step_t_c = smear_up(rs_t_q | add_t_c);
  end

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mr_d        = mr_q;
    mr_t_d      = mr_t_q;
    mc_d        = mc_q;
    mc_t_d      = mc_t_q;
    sm_d        = sm_q;
    sm_t_d      = sm_t_q;
    st_t_d      = st_t_q;
    md_d        = md_q;
    md_t_d      = md_t_q;
    rs_d        = rs_q;
    rs_t_d      = rs_t_q;
    product_d   = product_q;
    product_t_d = product_t_q;
    done_d      = done_q;
    done_t_d    = done_t_q;
    accept_c    = start & ((state_q == S_IDLE) | (state_q == S_DONE));

    case (state_q)
      S_IDLE: begin
        done_d   = 1'b0;
        done_t_d = 1'b0;
      end
      S_LOAD: begin
        rs_d   = '0;
        rs_t_d = '0;
        md_d   = {{(SW-WIDTH){sm_q & mc_q[WIDTH-1]}}, mc_q};
        md_t_d = {{(SW-WIDTH){sm_t_q | (sm_q & mc_t_q[WIDTH-1])}}, mc_t_q};
        cnt_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        rs_d   = sum_c;
        rs_t_d = step_t_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        product_d   = rs_q[PW-1:0];
        product_t_d = rs_t_q[PW-1:0] | {sm_t_q, {(PW-1){1'b0}}};
        done_d      = 1'b1;
        done_t_d    = st_t_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Accepting a new request latches operands and drops the previous result flag
    if (accept_c) begin
      mr_d        = multiplier;
      mr_t_d      = multiplier_t;
      mc_d        = multiplicand;
      mc_t_d      = multiplicand_t;
      sm_d        = signed_mode;
      sm_t_d      = signed_mode_t;
      st_t_d      = start_t;
      product_d   = product_q;
      product_t_d = product_t_q;
      done_d      = 1'b0;
      done_t_d    = 1'b0;
      state_d     = S_LOAD;
    end

    busy_d = (state_d == S_LOAD) | (state_d == S_RUN);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mr_q        <= '0;
      mr_t_q      <= '0;
      mc_q        <= '0;
      mc_t_q      <= '0;
      sm_q        <= 1'b0;
      sm_t_q      <= 1'b0;
      st_t_q      <= 1'b0;
      md_q        <= '0;
      md_t_q      <= '0;
      rs_q        <= '0;
      rs_t_q      <= '0;
      busy_q      <= 1'b0;
      product_q   <= '0;
      product_t_q <= '0;
      done_q      <= 1'b0;
      done_t_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mr_q        <= mr_d;
      mr_t_q      <= mr_t_d;
      mc_q        <= mc_d;
      mc_t_q      <= mc_t_d;
      sm_q        <= sm_d;
      sm_t_q      <= sm_t_d;
      st_t_q      <= st_t_d;
      md_q        <= md_d;
      md_t_q      <= md_t_d;
      rs_q        <= rs_d;
      rs_t_q      <= rs_t_d;
      busy_q      <= busy_d;
      product_q   <= product_d;
      product_t_q <= product_t_d;
      done_q      <= done_d;
      done_t_q    <= done_t_d;
    end
  end

  assign busy           = busy_q;
  assign busy_t         = st_t_q;
  assign product        = product_q;
  assign product_t      = product_t_q;
  assign product_done   = done_q;
  assign product_done_t = done_t_q;

endmodule

// File: tb/tb_seq_multiplier_taint_signed.sv
// Bench for seq_multiplier_taint_signed: WIDTH=8 directed table plus corner
// sequences, and a WIDTH=32 zero-taint regression against a reference product.
module tb_seq_multiplier_taint_signed;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        s8 = 0, s8_t = 0, sm8 = 0, sm8_t = 0;
  logic [7:0]  a8 = 0, a8_t = 0, b8 = 0, b8_t = 0;
  logic        busy8, busy8_t, d8, d8_t;
  logic [15:0] p8, p8_t;

  seq_multiplier_taint_signed #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .start(s8), .start_t(s8_t),
    .signed_mode(sm8), .signed_mode_t(sm8_t),
    .multiplier(a8), .multiplier_t(a8_t),
    .multiplicand(b8), .multiplicand_t(b8_t),
    .busy(busy8), .busy_t(busy8_t),
    .product(p8), .product_t(p8_t),
    .product_done(d8), .product_done_t(d8_t)
  );

  // WIDTH=32 instance
  logic        s32 = 0, sm32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic        busy32, busy32_t, d32, d32_t;
  logic [63:0] p32, p32_t;

  seq_multiplier_taint_signed #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .start(s32), .start_t(1'b0),
    .signed_mode(sm32), .signed_mode_t(1'b0),
    .multiplier(a32), .multiplier_t(32'h0),
    .multiplicand(b32), .multiplicand_t(32'h0),
    .busy(busy32), .busy_t(busy32_t),
    .product(p32), .product_t(p32_t),
    .product_done(d32), .product_done_t(d32_t)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  a_t;
    logic [7:0]  b;
    logic [7:0]  b_t;
    logic        sm;
    logic        sm_t;
    logic        st_t;
    logic [15:0] exp_p;
    logic [15:0] exp_pt;
    logic        exp_dt;
  } vec8_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic go8(input vec8_t v);
    @(negedge clk);
    a8 = v.a; a8_t = v.a_t; b8 = v.b; b8_t = v.b_t;
    sm8 = v.sm; sm8_t = v.sm_t; s8_t = v.st_t; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
  endtask

  // Counts edges after acceptance until product_done; -1 on timeout
  task automatic wait8(output int cyc);
    bit got = 0;
    cyc = -1;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(posedge clk); #1;
      if (d8) begin got = 1; cyc = k; end
    end
  endtask

  task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic sm);
    @(negedge clk);
    a32 = a; b32 = b; sm32 = sm; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
  endtask

  task automatic wait32(output int cyc);
    bit got = 0;
    cyc = -1;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(posedge clk); #1;
      if (d32) begin got = 1; cyc = k; end
    end
  endtask

  vec8_t vecs [12];
  vec8_t v;
  int    cyc;
  logic [31:0] ra, rb;
  logic        rsm;
  logic [63:0] rexp;
  longint      sa, sb;

  initial begin
    //               a      a_t    b      b_t   sm sm_t st_t exp_p     exp_pt  exp_dt
    vecs[0]  = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 16'hFE01, 16'h0000, 1'b0};
    vecs[1]  = '{8'h80, 8'h00, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000, 1'b0};
    vecs[2]  = '{8'hFF, 8'h00, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 16'hFFFD, 16'h0000, 1'b0};
    vecs[3]  = '{8'h01, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 16'h0001, 16'hFFFF, 1'b0};
    vecs[4]  = '{8'h00, 8'h10, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFF0, 1'b0};
    vecs[5]  = '{8'hFF, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 16'h02FD, 16'h0000, 1'b0};
    vecs[6]  = '{8'h7F, 8'h00, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 16'hC080, 16'h0000, 1'b0};
    vecs[7]  = '{8'h02, 8'h00, 8'h03, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0006, 16'hFF80, 1'b0};
    vecs[8]  = '{8'h03, 8'h00, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 16'h000F, 16'h0000, 1'b1};
    vecs[9]  = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0080, 16'hFF80, 1'b0};
    vecs[10] = '{8'h01, 8'h00, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 16'hFF80, 16'hFF80, 1'b0};
    vecs[11] = '{8'h80, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 16'hFF80, 16'hFF80, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy8), 64'h0);
    check("rst_product", 64'(p8), 64'h0);
    check("rst_product_t", 64'(p8_t), 64'h0);
    check("rst_done", 64'(d8), 64'h0);
    check("rst_done32", 64'(d32), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; consecutive vectors also exercise start-in-DONE
    for (int i = 0; i < 12; i++) begin
      go8(vecs[i]);
      check($sformatf("v%0d_busy", i), 64'(busy8), 64'h1);
      wait8(cyc);
      check($sformatf("v%0d_latency", i), 64'(cyc), 64'd10);
      check($sformatf("v%0d_product", i), 64'(p8), 64'(vecs[i].exp_p));
      check($sformatf("v%0d_product_t", i), 64'(p8_t), 64'(vecs[i].exp_pt));
      check($sformatf("v%0d_done_t", i), 64'(d8_t), 64'(vecs[i].exp_dt));
    end

    // start while busy is ignored: operands stay, latency unchanged
    v = '{8'h0C, 8'h00, 8'h0B, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0084, 16'h0000, 1'b0};
    go8(v);
    @(negedge clk);
    s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; a8_t = 8'hFF; s8_t = 1'b1; sm8 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    s8 = 1'b0; a8_t = 8'h00; s8_t = 1'b0; sm8 = 1'b0;
    wait8(cyc);
    check("busy_start_latency", 64'(cyc + 3), 64'd10);
    check("busy_start_product", 64'(p8), 64'h0084);
    check("busy_start_product_t", 64'(p8_t), 64'h0);
    check("busy_start_busy_t", 64'(busy8_t), 64'h0);

    // start in DONE: product_done falls on the next cycle
    v = '{8'h05, 8'h00, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0023, 16'h0000, 1'b0};
    go8(v);
    check("done_start_drop", 64'(d8), 64'h0);
    wait8(cyc);
    check("done_start_latency", 64'(cyc), 64'd10);
    check("done_start_product", 64'(p8), 64'h0023);

    // Reset in RUN at counter=3 clears everything
    v = '{8'h33, 8'h01, 8'h44, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
    go8(v);
    check("mid_busy_t", 64'(busy8_t), 64'h1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", 64'(busy8), 64'h0);
    check("mid_rst_busy_t", 64'(busy8_t), 64'h0);
    check("mid_rst_product", 64'(p8), 64'h0);
    check("mid_rst_product_t", 64'(p8_t), 64'h0);
    check("mid_rst_done", 64'(d8), 64'h0);
    check("mid_rst_done_t", 64'(d8_t), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    v = '{8'h03, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0009, 16'h0000, 1'b0};
    go8(v);
    wait8(cyc);
    check("post_rst_latency", 64'(cyc), 64'd10);
    check("post_rst_product", 64'(p8), 64'h0009);

    // WIDTH=32 zero-taint regression, both modes, with extreme corners
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rsm = (i % 2) == 1;
      if (i == 0) begin ra = 32'h8000_0000; rb = 32'h8000_0000; rsm = 1'b1; end
      if (i == 1) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; rsm = 1'b0; end
      if (i == 2) begin ra = 32'hFFFF_FFFF; rb = 32'h0000_0003; rsm = 1'b1; end
      if (rsm) begin
        sa   = longint'($signed(ra));
        sb   = longint'($signed(rb));
        rexp = 64'(sa * sb);
      end else begin
        rexp = {32'h0, ra} * {32'h0, rb};
      end
      go32(ra, rb, rsm);
      wait32(cyc);
      check($sformatf("r%0d_latency", i), 64'(cyc), 64'd34);
      check($sformatf("r%0d_product", i), p32, rexp);
      check($sformatf("r%0d_product_t", i), p32_t, 64'h0);
      check($sformatf("r%0d_done_t", i), 64'(d32_t), 64'h0);
      check($sformatf("r%0d_busy_t", i), 64'(busy32_t), 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
